// File: rtl/float_pkg.sv
// Shared single-precision float definitions for the Phaethon float datapath.
package float_pkg;

    localparam int          FLT_EXP_BIAS = 127;
    localparam logic [7:0]  FLT_EXP_MAX  = 8'hFF;
    localparam int          FLT_MANT_W   = 24;
    localparam int          DIV_ITER     = 25;
    localparam int          DIV_CNT_W    = $clog2(DIV_ITER);
    localparam logic [31:0] FLT_QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] FLT_INF      = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DIVIDE,
        NORMALIZE,
        DONE
    } div_state_e;

    typedef struct packed {
        logic                  sign;
        logic [7:0]            exp;
        logic [FLT_MANT_W-1:0] mant;     // hidden bit included; zero for a zero operand
        logic                  is_zero;
        logic                  is_inf;
    } flt_unpacked_t;

    // No denormals: exponent 0 is zero regardless of fraction; 0xFF is infinity.
    function automatic flt_unpacked_t flt_unpack(input logic [31:0] x);
        flt_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.is_zero = (x[30:23] == 8'h00);
        u.is_inf  = (x[30:23] == FLT_EXP_MAX);
        u.mant    = u.is_zero ? '0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/float_divide_mantissa_divider.sv
// Restoring mantissa divider: one quotient bit per step, DIV_ITER steps,
// producing floor(ma * 2^(DIV_ITER-1) / mb).
module mantissa_divider
    import float_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [FLT_MANT_W-1:0] ma,
    input  logic [FLT_MANT_W-1:0] mb,
    output logic [DIV_ITER-1:0]   quot,
    output logic                  last
);

    logic [DIV_ITER-1:0]   rem_q, rem_d;
    logic [DIV_ITER-1:0]   quot_q, quot_d;
    logic [FLT_MANT_W-1:0] mb_q, mb_d;
    logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  ge;
    logic [DIV_ITER-1:0]   rem_sub;

    // Next-state for one restoring step; the remainder stays below 2*mb so
    // DIV_ITER bits are enough and the shifted-out MSB is always zero.
    always_comb begin
        rem_d   = rem_q;
        quot_d  = quot_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        ge      = (rem_q >= {1'b0, mb_q});
        rem_sub = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        if (load) begin
            rem_d  = {1'b0, ma};
            quot_d = '0;
            mb_d   = mb;
            cnt_d  = DIV_CNT_W'(DIV_ITER - 1);
        end else if (step) begin
            quot_d = {quot_q[DIV_ITER-2:0], ge};
            rem_d  = rem_sub << 1;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quot_q <= '0;
            mb_q   <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            mb_q   <= mb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign quot = quot_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/float_divide.sv
// Iterative single-precision divider, fixed 29-cycle start-to-start latency,
// truncating, no denormals. FSM, exponent/sign path, specials and packing.
module float_divide
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    div_state_e         state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [31:0]        res_q, res_d;
    logic               res_dbz_q, res_dbz_d;
    logic [31:0]        out_q, out_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    flt_unpacked_t      ua, ub;
    logic               div_load, div_step, div_last;
    logic [DIV_ITER-1:0] div_quot;
    logic signed [9:0]  norm_exp;
    logic [22:0]        norm_mant;
    logic [31:0]        norm_res, res_val;
    logic               res_dbz_val;

    assign ua = flt_unpack(a_q);
    assign ub = flt_unpack(b_q);

    mantissa_divider u_mdiv (
        .clk   (clk),
        .reset (reset),
        .load  (div_load),
        .step  (div_step),
        .ma    (ua.mant),
        .mb    (ub.mant),
        .quot  (div_quot),
        .last  (div_last)
    );

    // Normalize the quotient and apply special-operand overrides.
    always_comb begin
        norm_exp    = div_quot[24] ? exp_q : (exp_q - 10'sd1);
        norm_mant   = div_quot[24] ? div_quot[23:1] : div_quot[22:0];
        if (norm_exp >= 10'sd255)
            norm_res = {sign_q, FLT_INF[30:0]};
        else if (norm_exp <= 10'sd0)
            norm_res = {sign_q, 31'b0};
        else
            norm_res = {sign_q, norm_exp[7:0], norm_mant};

        res_dbz_val = 1'b0;
        if ((ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
            res_val = FLT_QNAN;
        end else if (ua.is_zero) begin
            res_val = {sign_q, 31'b0};
        end else if (ua.is_inf) begin
            res_val = {sign_q, FLT_INF[30:0]};
        end else if (ub.is_zero) begin
            res_val     = {sign_q, FLT_INF[30:0]};
            res_dbz_val = 1'b1;
        end else if (ub.is_inf) begin
            res_val = {sign_q, 31'b0};
        end else begin
            res_val = norm_res;
        end
    end

    // FSM next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        res_d     = res_q;
        res_dbz_d = res_dbz_q;
        out_d     = out_q;
        dbz_d     = dbz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                sign_d   = ua.sign ^ ub.sign;
                // Modular 10-bit arithmetic yields the signed difference directly.
                exp_d    = 10'({2'b00, ua.exp}) - 10'({2'b00, ub.exp}) + 10'(FLT_EXP_BIAS);
                div_load = 1'b1;
                state_d  = DIVIDE;
            end
            DIVIDE: begin
                div_step = 1'b1;
                if (div_last) state_d = NORMALIZE;
            end
            NORMALIZE: begin
                res_d     = res_val;
                res_dbz_d = res_dbz_val;
                state_d   = DONE;
            end
            DONE: begin
                out_d   = res_q;
                dbz_d   = res_dbz_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            res_q     <= '0;
            res_dbz_q <= 1'b0;
            out_q     <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            res_q     <= res_d;
            res_dbz_q <= res_dbz_d;
            out_q     <= out_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out         = out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_float_divide.sv
// Directed bench for float_divide: hand-computed quotients, latency,
// handshake, specials and mid-operation reset.
module tb_float_divide;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic [31:0] out;
    logic        busy, done, div_by_zero;

    int vectors     = 0;
    int miscompares = 0;

    float_divide dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .out         (out),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Present operands with start for one cycle; returns just after edge 0.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tbv);
        @(negedge clk);
        a = ta; b = tbv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called just after edge 0; returns just after the edge raising done.
    task automatic wait_check(input string tag, input logic [31:0] exp_out, input logic exp_dbz);
        int n = 0;
        logic busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "/latency"}, 32'(n), 32'd28);
        chk({tag, "/busy_held"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, "/out"}, out, exp_out);
        chk({tag, "/dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
        chk({tag, "/busy_low"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                         input logic [31:0] exp_out, input logic exp_dbz);
        start_op(ta, tbv);
        wait_check(tag, exp_out, exp_dbz);
        @(negedge clk);
        chk({tag, "/done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int dones;
        int done_at;
        logic busy_seen;

        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        chk("rst/out", out, 32'h0);
        chk("rst/ctl", {29'b0, busy, done, div_by_zero}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        do_op("6/2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
        do_op("1/3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0);
        do_op("0/5",      32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0);
        do_op("0/0",      32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0);
        do_op("ovf",      32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0);
        do_op("unf",      32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0);
        do_op("inf/inf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0);
        do_op("-inf/2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
        do_op("2/-inf",   32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0);
        do_op("-1/0",     32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1);

        // Back-to-back: next start presented in the done cycle, sampled on edge 29.
        start_op(32'h40C0_0000, 32'hC000_0000);
        wait_check("b2b1", 32'hC040_0000, 1'b0);
        a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b2/accepted", {30'b0, busy, done}, 32'h2);
        wait_check("b2b2", 32'h3EAA_AAAA, 1'b0);

        // Start re-pulsed while busy and held high through DONE: ignored.
        @(negedge clk);
        start_op(32'h40C0_0000, 32'h4000_0000);
        dones = 0; done_at = -1;
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin dones++; done_at = i; end
            if (i == 5)  begin start = 1'b1; a = 32'h3F80_0000; b = 32'h4040_0000; end
            if (i == 6)  start = 1'b0;
            if (i == 20) begin start = 1'b1; b = 32'h4080_0000; end
            if (i == 28) start = 1'b0;
        end
        chk("hold/done_at", 32'(done_at), 32'd28);
        chk("hold/out", out, 32'h4040_0000);
        busy_seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        chk("hold/done_count", 32'(dones), 32'd1);
        chk("hold/no_restart", {31'b0, busy_seen}, 32'd0);

        // Reset mid-operation at edge 10; previous result was -1/0.
        do_op("pre_rst", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1);
        start_op(32'h40C0_0000, 32'h4000_0000);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst/out", out, 32'h0);
        chk("midrst/ctl", {29'b0, busy, done, div_by_zero}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("midrst/no_done", 32'(dones), 32'd0);
        do_op("post_rst", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
